uart_alu_frame_iface: RTL and testbench

//  Parametrised successor of the byte-wide UART<->ALU interface. Assembles multi-byte operands A, B and an

---
 rtl/uart_alu_frame_iface.sv | 169 ++++++++++++++++
 tb/tb_uart_alu_frame_iface.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frame_iface.sv
// UART <-> ALU frame interface: assembles A, B and opcode bytes, returns the result LSB byte first.
// Optional checksum byte after the result: define ALU_IFACE_CHECKSUM_EN.
module uart_alu_frame_iface #(
    parameter int NB_BYTE        = 8,
    parameter int NB_DATA        = 16,
    parameter int NB_OPERATION   = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NB_BYTE-1:0]      i_rx_data,
    input  logic                    i_rx_done,
    input  logic                    i_tx_done,
    input  logic [NB_DATA-1:0]      i_alu_data,
    output logic [NB_DATA-1:0]      o_alu_data_a,
    output logic [NB_DATA-1:0]      o_alu_data_b,
    output logic [NB_OPERATION-1:0] o_alu_data_op,
    output logic [NB_BYTE-1:0]      o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic                    o_overrun
);
    localparam int N_BYTES = NB_DATA / NB_BYTE;
`ifdef ALU_IFACE_CHECKSUM_EN
    localparam int N_TX = N_BYTES + 1;
`else
    localparam int N_TX = N_BYTES;
`endif
    localparam int IDX_W = $clog2(N_BYTES + 2);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_RX = IDX_W'(N_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_TX = IDX_W'(N_TX - 1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CYCLES - 1);

    // state    | meaning
    // RX_A     | collecting operand A bytes
    // RX_B     | collecting operand B bytes
    // RX_OP    | waiting for the opcode byte
    // EXEC     | latch alu result
    // TX_START | pulse uart_tx start with result byte[idx]
    // TX_WAIT  | wait for uart_tx done
    typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_START, TX_WAIT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0] a_q, b_q, res_q;
    logic [NB_OPERATION-1:0] op_q;
    logic               wr_a, wr_b, wr_op, rx_state, started, tmo, ovr;
    logic [NB_BYTE-1:0] tx_byte;
`ifdef ALU_IFACE_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        wr_op    = 1'b0;
        tmo      = 1'b0;
        ovr      = 1'b0;
        rx_state = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
        started  = !((state_q == RX_A) && (idx_q == '0));
        if (rx_state) begin
            if (i_rx_done) begin
                cnt_d = '0;
                case (state_q)
                    RX_A: begin
                        wr_a = 1'b1;
                        if (idx_q == LAST_RX) begin
                            state_d = RX_B;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    RX_B: begin
                        wr_b = 1'b1;
                        if (idx_q == LAST_RX) begin
                            state_d = RX_OP;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    default: begin
                        wr_op   = 1'b1;
                        state_d = EXEC;
                        idx_d   = '0;
                    end
                endcase
            end else if (started) begin
                // a byte arriving on the terminal count is taken above instead
                if (cnt_q == CNT_TC) begin
                    tmo     = 1'b1;
                    state_d = RX_A;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            ovr = i_rx_done;
            case (state_q)
                EXEC:     state_d = TX_START;
                TX_START: state_d = TX_WAIT;
                TX_WAIT: begin
                    if (i_tx_done) begin
                        if (idx_q == LAST_TX) begin
                            state_d = RX_A;
                            idx_d   = '0;
                        end else begin
                            state_d = TX_START;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_byte = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) tx_byte = res_q[i*NB_BYTE +: NB_BYTE];
        end
`ifdef ALU_IFACE_CHECKSUM_EN
        csum = '0;
        for (int i = 0; i < N_BYTES; i++) csum = csum ^ res_q[i*NB_BYTE +: NB_BYTE];
        if (idx_q == IDX_W'(N_BYTES)) tx_byte = csum;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= RX_A;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (state_q == EXEC) res_q <= i_alu_data;
            for (int i = 0; i < N_BYTES; i++) begin
                if (wr_a && idx_q == IDX_W'(i)) a_q[i*NB_BYTE +: NB_BYTE] <= i_rx_data;
                if (wr_b && idx_q == IDX_W'(i)) b_q[i*NB_BYTE +: NB_BYTE] <= i_rx_data;
            end
            if (wr_op) op_q <= i_rx_data[NB_OPERATION-1:0];
        end
    end

    assign o_alu_data_a  = a_q;
    assign o_alu_data_b  = b_q;
    assign o_alu_data_op = op_q;
    assign o_tx_start    = (state_q == TX_START);
    assign o_tx_data     = o_tx_start ? tx_byte : '0;
    assign o_busy        = !rx_state;
    assign o_timeout     = tmo;
    assign o_overrun     = ovr;
endmodule

// File: tb/tb_uart_alu_frame_iface.sv
// Bench for uart_alu_frame_iface: 16-bit instance with scoreboarded tx bytes, plus an 8-bit instance.
module tb_uart_alu_frame_iface;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        resp_done = 1'b0;
    logic        tx_done;
    logic [15:0] alu_res, a_o, b_o;
    logic [5:0]  op_o;
    logic [7:0]  tx_data;
    logic        tx_start, busy, timeout, overrun;

    logic [7:0]  rx_data8 = '0;
    logic        rx_done8 = 1'b0;
    logic        tx_done8 = 1'b0;
    logic [15:0] alu8_full;
    logic [7:0]  alu8, a8, b8, tx_data8;
    logic [5:0]  op8;
    logic        tx_start8, busy8, timeout8, overrun8;

    int checks = 0;
    int errors = 0;
    int tmo_cnt = 0;
    int ovr_cnt = 0;
    logic waiting = 1'b0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  opb;
        logic [5:0]  op;
        logic [15:0] res;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;
    assign tx_done = resp_done;

    function automatic logic [15:0] alu16(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_res   = alu16(a_o, b_o, op_o);
    assign alu8_full = alu16({8'h00, a8}, {8'h00, b8}, op8);
    assign alu8      = alu8_full[7:0];

    uart_alu_frame_iface #(.NB_BYTE(8), .NB_DATA(16), .NB_OPERATION(6), .TIMEOUT_CYCLES(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done), .i_tx_done(tx_done),
        .i_alu_data(alu_res), .o_alu_data_a(a_o), .o_alu_data_b(b_o), .o_alu_data_op(op_o),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_timeout(timeout), .o_overrun(overrun));

    uart_alu_frame_iface #(.NB_BYTE(8), .NB_DATA(8), .NB_OPERATION(6), .TIMEOUT_CYCLES(64)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data8), .i_rx_done(rx_done8), .i_tx_done(tx_done8),
        .i_alu_data(alu8), .o_alu_data_a(a8), .o_alu_data_b(b8), .o_alu_data_op(op8),
        .o_tx_data(tx_data8), .o_tx_start(tx_start8), .o_busy(busy8), .o_timeout(timeout8), .o_overrun(overrun8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // tx monitor: every start is checked against the scoreboard and must not overlap a pending byte
    always @(negedge clk) begin
        if (tx_done) waiting <= 1'b0;
        if (tx_start) begin
            chk("tx_not_overlapped", 32'(waiting), 32'd0);
            if (sb_q.size() == 0) begin
                chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte", 32'(tx_data), 32'(sb_q.pop_front()));
            end
            waiting <= 1'b1;
        end
        if (timeout) tmo_cnt++;
        if (overrun) ovr_cnt++;
    end

    initial begin : responder
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (3) @(posedge clk);
                #2 resp_done = 1'b1;
                @(posedge clk);
                #2 resp_done = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #2 rx_done = 1'b0;
    endtask

    task automatic push_result(input logic [15:0] res);
        sb_q.push_back(res[7:0]);
        sb_q.push_back(res[15:8]);
`ifdef ALU_IFACE_CHECKSUM_EN
        sb_q.push_back(res[7:0] ^ res[15:8]);
`endif
    endtask

    // returns at the negedge of the first TX_START cycle
    task automatic send_frame(input vec_t v);
        push_result(v.res);
        idle(1);
        send_byte(v.a[7:0]);  idle($urandom_range(0, 3));
        send_byte(v.a[15:8]); idle($urandom_range(0, 3));
        send_byte(v.b[7:0]);  idle($urandom_range(0, 3));
        send_byte(v.b[15:8]); idle($urandom_range(0, 3));
        send_byte(v.opb);
        @(negedge clk);
        chk("reg_a", 32'(a_o), 32'(v.a));
        chk("reg_b", 32'(b_o), 32'(v.b));
        chk("reg_op", 32'(op_o), 32'(v.op));
        chk("exec_no_start", 32'(tx_start), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("start_latency", 32'(tx_start), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, 32'(busy), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic send8(input logic [7:0] b);
        rx_data8 = b;
        rx_done8 = 1'b1;
        @(posedge clk);
        #2 rx_done8 = 1'b0;
    endtask

    task automatic tx8_expect(input logic [7:0] exp, input int exp_lat);
        int lat;
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (tx_start8) begin
                lat = n;
                break;
            end
        end
        chk("n8_latency", 32'(lat), 32'(exp_lat));
        chk("n8_tx_byte", 32'(tx_data8), 32'(exp));
        @(posedge clk);
        #2 tx_done8 = 1'b1;
        @(posedge clk);
        #2 tx_done8 = 1'b0;
    endtask

    initial begin : main
        int t0, o0, pos, seen;
        vec_t v;
        vecs[0] = '{a: 16'h1234, b: 16'h0001, opb: 8'h20, op: 6'h20, res: 16'h1235};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, opb: 8'h20, op: 6'h20, res: 16'h0000};
        vecs[2] = '{a: 16'h00F0, b: 16'h0010, opb: 8'h22, op: 6'h22, res: 16'h00E0};
        vecs[3] = '{a: 16'hF0F0, b: 16'hFF00, opb: 8'h24, op: 6'h24, res: 16'hF000};
        vecs[4] = '{a: 16'hA5A5, b: 16'h5A5A, opb: 8'h26, op: 6'h26, res: 16'hFFFF};
        vecs[5] = '{a: 16'h0102, b: 16'h0304, opb: 8'hE0, op: 6'h20, res: 16'h0406};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_a", 32'(a_o), 32'd0);
        chk("rst_b", 32'(b_o), 32'd0);
        chk("rst_op", 32'(op_o), 32'd0);
        chk("rst_outs", 32'({tx_data, tx_start, busy, timeout, overrun}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i]);
            wait_idle("vec_idle");
        end

        // inter-byte timeout with a partial A operand
        idle(1);
        t0 = tmo_cnt;
        send_byte(8'h78);
        send_byte(8'h56);
        pos = -1;
        seen = 0;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (timeout) begin
                seen++;
                pos = j;
            end
        end
        chk("tmo_pulses", 32'(seen), 32'd1);
        chk("tmo_position", 32'(pos), 32'd64);
        chk("tmo_keep_a", 32'(a_o), 32'h5678);
        chk("tmo_not_busy", 32'(busy), 32'd0);
        send_frame(vecs[0]);
        wait_idle("tmo_recover_idle");

        // byte exactly on the terminal count wins over the timeout
        idle(1);
        t0 = tmo_cnt;
        send_byte(8'h11);
        idle(63);
        v = '{a: 16'h2211, b: 16'h4433, opb: 8'h20, op: 6'h20, res: 16'h6644};
        push_result(v.res);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h20);
        @(negedge clk);
        chk("tc_reg_a", 32'(a_o), 32'h2211);
        chk("tc_reg_b", 32'(b_o), 32'h4433);
        wait_idle("tc_idle");
        chk("tc_no_timeout", 32'(tmo_cnt - t0), 32'd0);

        // overrun during TX_WAIT
        o0 = ovr_cnt;
        send_frame(vecs[0]);
        idle(1);
        send_byte(8'hAA);
        @(negedge clk);
        chk("ovr_keep_a", 32'(a_o), 32'h1234);
        wait_idle("ovr_idle");
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);

        // reset in TX_WAIT of byte 0; the pending tx_done arrives afterwards and must be ignored
        send_frame(vecs[2]);
        idle(1);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("mid_rst_regs", 32'(a_o | b_o), 32'd0);
        chk("mid_rst_outs", 32'({op_o, tx_data, tx_start, busy, timeout, overrun}), 32'd0);
        idle(12);
        chk("mid_rst_still_idle", 32'(busy), 32'd0);
        send_frame(vecs[3]);
        wait_idle("post_rst_idle");

        // 8-bit instance: single result byte
        idle(1);
        send8(8'h05);
        send8(8'h03);
        send8(8'h20);
        tx8_expect(8'h08, 1);
`ifdef ALU_IFACE_CHECKSUM_EN
        tx8_expect(8'h08, 0);
`endif
        seen = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (tx_start8) seen = 2;
            if (!busy8) begin
                seen = (seen == 2) ? 2 : 0;
                break;
            end
        end
        chk("n8_done_idle", 32'(seen), 32'd0);
        chk("n8_flags", 32'({timeout8, overrun8}), 32'd0);
        chk("total_timeouts", 32'(tmo_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
